// File: rtl/fir_mc_tdm.sv
// rtl/fir_mc_tdm.sv - time-multiplexed multi-channel FIR with banked coefficients
// One shared multiplier walks every tap of every channel per accepted sample set.
module fir_mc_tdm #(
  parameter int CHANNELS = 3,
  parameter int TAPS     = 16,
  parameter int BANKS    = 4,
  parameter int DATA_W   = 16,
  parameter int COEFF_W  = 16,
  parameter int SHIFT    = 14,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int TAP_W   = $clog2(TAPS)
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic [CHANNELS*BANK_W-1:0]   bank_sel,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [CH_W-1:0]              upd_chan,
  input  logic [BANK_W-1:0]            upd_bank,
  input  logic [TAP_W-1:0]             upd_index,
  input  logic signed [COEFF_W-1:0]    upd_value,
  output logic                         out_valid,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic [CHANNELS-1:0]          out_sat
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + TAP_W;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic signed [COEFF_W-1:0] COEFF_ONE = COEFF_W'(1 << SHIFT);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                      state_q, state_d;
  logic signed [DATA_W-1:0]    dl_q    [CHANNELS][TAPS];
  logic signed [COEFF_W-1:0]   coeff_q [CHANNELS][BANKS][TAPS];
  logic [BANK_W-1:0]           bank_q  [CHANNELS];
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [TAP_W-1:0]            tap_q, tap_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]           res_q   [CHANNELS];
  logic [CHANNELS-1:0]         res_sat_q;
  logic [CHANNELS*DATA_W-1:0]  out_data_q;
  logic [CHANNELS-1:0]         out_sat_q;

  logic                        pend_q;
  logic [CH_W-1:0]             pend_chan_q;
  logic [BANK_W-1:0]           pend_bank_q;
  logic [TAP_W-1:0]            pend_idx_q;
  logic signed [COEFF_W-1:0]   pend_val_q;

  logic                        accept;
  logic                        mac_last_tap;
  logic                        mac_done;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [ACC_W-1:0]     shifted;
  logic [DATA_W-1:0]           ch_res;
  logic                        ch_sat;
  logic                        upd_fire;
  logic                        upd_ok;
  logic                        upd_hit;
  logic                        pend_load;
  logic                        pend_commit;
  logic                        direct_wr;

  assign accept       = (state_q == IDLE) && in_valid;
  assign mac_last_tap = (state_q == MAC) && (tap_q == LAST_TAP);
  assign mac_done     = mac_last_tap && (ch_q == LAST_CH);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MAC;
      end
      MAC: begin
        if (mac_done) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d  = ch_q;
    tap_d = tap_q;
    if (accept) begin
      ch_d  = '0;
      tap_d = '0;
    end else if (state_q == MAC) begin
      tap_d = tap_q + 1'b1;
      if (mac_last_tap) ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
    end
  end

  // Accumulator restarts at tap 0 of every channel; its extra TAP_W bits rule out wrap.
  always_comb begin
    prod    = PROD_W'(dl_q[ch_q][tap_q]) * PROD_W'(coeff_q[ch_q][bank_q[ch_q]][tap_q]);
    acc_sum = ((tap_q == '0) ? '0 : acc_q) + ACC_W'(prod);
    acc_d   = (state_q == MAC) ? acc_sum : acc_q;
    shifted = acc_sum >>> SHIFT;
    ch_sat  = 1'b0;
    ch_res  = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      ch_res = OUT_MAX;
      ch_sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      ch_res = OUT_MIN;
      ch_sat = 1'b1;
    end
  end

  // Writes hitting a bank in use during MAC are parked; in OUT the MAC is finished,
  // so writes go straight in alongside the parked one (newer value wins on a clash).
  always_comb begin
    upd_ready   = !pend_q || (state_q == OUT);
    upd_fire    = upd_valid && upd_ready;
    upd_ok      = (upd_chan <= LAST_CH);
    upd_hit     = (state_q == MAC) && upd_ok && (bank_q[upd_chan] == upd_bank);
    pend_load   = upd_fire && upd_hit;
    direct_wr   = upd_fire && !upd_hit && upd_ok;
    pend_commit = (state_q == OUT) && pend_q;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        bank_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) dl_q[c][t] <= '0;
      end
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        bank_q[c]  <= bank_sel[c*BANK_W +: BANK_W];
        dl_q[c][0] <= in_data[c*DATA_W +: DATA_W];
        for (int t = 1; t < TAPS; t++) dl_q[c][t] <= dl_q[c][t-1];
      end
    end
  end

  // The last channel's result bypasses res_q so every output lands on the same edge.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) res_q[c] <= '0;
      res_sat_q  <= '0;
      out_data_q <= '0;
      out_sat_q  <= '0;
    end else if (mac_last_tap) begin
      if (ch_q == LAST_CH) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (c == CHANNELS - 1) begin
            out_data_q[c*DATA_W +: DATA_W] <= ch_res;
            out_sat_q[c]                   <= ch_sat;
          end else begin
            out_data_q[c*DATA_W +: DATA_W] <= res_q[c];
            out_sat_q[c]                   <= res_sat_q[c];
          end
        end
      end else begin
        res_q[ch_q]     <= ch_res;
        res_sat_q[ch_q] <= ch_sat;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= 1'b0;
      pend_chan_q <= '0;
      pend_bank_q <= '0;
      pend_idx_q  <= '0;
      pend_val_q  <= '0;
    end else if (pend_load) begin
      pend_q      <= 1'b1;
      pend_chan_q <= upd_chan;
      pend_bank_q <= upd_bank;
      pend_idx_q  <= upd_index;
      pend_val_q  <= upd_value;
    end else if (pend_commit) begin
      pend_q <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int b = 0; b < BANKS; b++)
          for (int t = 0; t < TAPS; t++)
            coeff_q[c][b][t] <= (b == 0 && t == 0) ? COEFF_ONE : '0;
    end else begin
      if (pend_commit) coeff_q[pend_chan_q][pend_bank_q][pend_idx_q] <= pend_val_q;
      if (direct_wr)   coeff_q[upd_chan][upd_bank][upd_index] <= upd_value;
    end
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;

endmodule
